// File: rtl/dvp_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dvp_pkg                                                                   |
// | Shared state encoding and time conversion for the DVP sensor sequencer.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package dvp_pkg;

    typedef enum logic [2:0] {
        S_PWDN  = 3'd0,
        S_RESET = 3'd1,
        S_BOOT  = 3'd2,
        S_CFG   = 3'd3,
        S_WAIT  = 3'd4,
        S_READY = 3'd5,
        S_FAULT = 3'd6
    } seq_state_e;

    function automatic int unsigned us_to_cycles(input int unsigned hz, input int unsigned us);
        return (hz / 32'd1_000_000) * us;
    endfunction

endpackage : dvp_pkg
`default_nettype wire

// File: rtl/dvp_sensor_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dvp_sensor_seq                                                            |
// | Sensor power-up, SCCB config handshake, retry with power cycle, fault.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module dvp_sensor_seq
    import dvp_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 24_000_000,
    parameter int unsigned T_PWDN_US      = 1_000,
    parameter int unsigned T_RST_US       = 1_000,
    parameter int unsigned T_BOOT_US      = 20_000,
    parameter int unsigned CFG_TIMEOUT_US = 100_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       dvp_clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       cfg_done,
    input  logic       cfg_err,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam int unsigned N_PWDN = us_to_cycles(CLK_HZ, T_PWDN_US);
    localparam int unsigned N_RST  = us_to_cycles(CLK_HZ, T_RST_US);
    localparam int unsigned N_BOOT = us_to_cycles(CLK_HZ, T_BOOT_US);
    localparam int unsigned N_TO   = us_to_cycles(CLK_HZ, CFG_TIMEOUT_US);

    localparam int unsigned N_MAX_A = (N_PWDN > N_RST)   ? N_PWDN  : N_RST;
    localparam int unsigned N_MAX_B = (N_BOOT > N_TO)    ? N_BOOT  : N_TO;
    localparam int unsigned N_MAX   = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;

    localparam int TW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] PWDN_LAST = TW'(N_PWDN - 1);
    localparam logic [TW-1:0] RST_LAST  = TW'(N_RST - 1);
    localparam logic [TW-1:0] BOOT_LAST = TW'(N_BOOT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(N_TO - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    if ((N_PWDN < 1) || (N_RST < 1) || (N_BOOT < 1) || (N_TO < 1)) begin : g_bad_timing
        $error("dvp_sensor_seq: every phase must last at least one dvp_clk cycle");
    end
    if (MAX_RETRY < 1) begin : g_bad_retry
        $error("dvp_sensor_seq: MAX_RETRY must be at least 1");
    end

    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic [RW-1:0] retry_inc;

    logic cam_pwdn_q, cam_pwdn_d;
    logic cam_rst_n_q, cam_rst_n_d;
    logic cfg_start_q, cfg_start_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    assign retry_inc = retry_cnt_q + RW'(1);

    // restart outranks everything; inside S_WAIT an error or timeout outranks done
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        if (restart) begin
            state_d     = S_PWDN;
            retry_cnt_d = '0;
        end else begin
            case (state_q)
                S_PWDN:  if (timer_q == PWDN_LAST) state_d = S_RESET;
                S_RESET: if (timer_q == RST_LAST)  state_d = S_BOOT;
                S_BOOT:  if (timer_q == BOOT_LAST) state_d = S_CFG;
                S_CFG:   state_d = S_WAIT;
                S_WAIT: begin
                    if (cfg_err || (timer_q == TO_LAST)) begin
                        retry_cnt_d = retry_inc;
                        state_d     = (retry_inc < RETRY_LIM) ? S_PWDN : S_FAULT;
                    end else if (cfg_done) begin
                        state_d = S_READY;
                    end
                end
                S_READY: state_d = S_READY;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_PWDN;
            endcase
        end
    end

    // Terminal states hold the timer at zero so it never wraps while idle
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (restart || (state_d != state_q) ||
            (state_q == S_READY) || (state_q == S_FAULT)) begin
            timer_d = '0;
        end
    end

    // Outputs decoded from the next state so the registered pins line up with state_q
    always_comb begin
        cam_pwdn_d  = (state_d == S_PWDN) || (state_d == S_FAULT);
        cam_rst_n_d = (state_d == S_BOOT) || (state_d == S_CFG) ||
                      (state_d == S_WAIT) || (state_d == S_READY);
        cfg_start_d = (state_d == S_CFG);
        ready_d     = (state_d == S_READY);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge dvp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWDN;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            cam_pwdn_q  <= cam_pwdn_d;
            cam_rst_n_q <= cam_rst_n_d;
            cfg_start_q <= cfg_start_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign cam_pwdn  = cam_pwdn_q;
    assign cam_rst_n = cam_rst_n_q;
    assign cfg_start = cfg_start_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign state_dbg = state_q;

endmodule : dvp_sensor_seq
`default_nettype wire

// File: tb/tb_dvp_sensor_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dvp_sensor_seq                                                         |
// | Directed table, hand sequences and random stimulus against a timeline     |
// | model of the sensor power-up / config sequencer.                          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_dvp_sensor_seq;

    localparam int T_PW   = 4;
    localparam int T_RS   = 3;
    localparam int T_BT   = 5;
    localparam int T_TO   = 10;
    localparam int RETRY  = 2;
    // Attempt timeline in cycles since the attempt began
    localparam int T_CFG  = T_PW + T_RS + T_BT;
    localparam int T_WAIT = T_CFG + 1;
    localparam int T_LAST = T_WAIT + T_TO - 1;

    localparam logic [7:0] RESET_VEC = 8'b1000_0000;

    logic       dvp_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       restart = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cfg_err  = 1'b0;
    logic       cam_pwdn, cam_rst_n, cfg_start, ready, fault;
    logic [2:0] state_dbg;
    logic [7:0] dut_vec;

    int n_total = 0;
    int n_pass  = 0;

    // Model: mode 0 = sequencing, 1 = ready, 2 = fault
    int m_mode = 0;
    int m_t    = 0;
    int m_att  = 0;

    dvp_sensor_seq #(
        .CLK_HZ        (1_000_000),
        .T_PWDN_US     (T_PW),
        .T_RST_US      (T_RS),
        .T_BOOT_US     (T_BT),
        .CFG_TIMEOUT_US(T_TO),
        .MAX_RETRY     (RETRY)
    ) dut (
        .dvp_clk  (dvp_clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .cam_pwdn (cam_pwdn),
        .cam_rst_n(cam_rst_n),
        .cfg_start(cfg_start),
        .ready    (ready),
        .fault    (fault),
        .state_dbg(state_dbg)
    );

    always #5 dvp_clk = ~dvp_clk;

    assign dut_vec = {cam_pwdn, cam_rst_n, cfg_start, ready, fault, state_dbg};

    typedef struct {
        int         n;
        bit         rs;
        bit         dn;
        bit         er;
        logic [7:0] exp;
    } vec_t;

    // Expected pins {pwdn, rst_n, cfg_start, ready, fault, state[2:0]}
    function automatic logic [7:0] model_out();
        if (m_mode == 1) return 8'b0101_0101;
        if (m_mode == 2) return 8'b1000_1110;
        if (m_t < T_PW) return 8'b1000_0000;
        if (m_t < T_PW + T_RS) return 8'b0000_0001;
        if (m_t < T_CFG) return 8'b0100_0010;
        if (m_t == T_CFG) return 8'b0110_0011;
        return 8'b0100_0100;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_att  = 0;
    endtask

    task automatic model_edge(input bit rs, input bit dn, input bit er);
        if (rs) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (m_t >= T_WAIT && (er || m_t == T_LAST)) begin
                m_att = m_att + 1;
                if (m_att < RETRY) m_t = 0;
                else m_mode = 2;
            end else if (m_t >= T_WAIT && dn) begin
                m_mode = 1;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit rs, input bit dn, input bit er);
        restart  = rs;
        cfg_done = dn;
        cfg_err  = er;
        @(posedge dvp_clk);
        model_edge(rs, dn, er);
        #1;
        restart  = 1'b0;
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        // nominal bring-up, then restart
        vt.push_back('{1,  0, 0, 0, 8'b1000_0000});
        vt.push_back('{3,  0, 0, 0, 8'b0000_0001});
        vt.push_back('{3,  0, 0, 0, 8'b0100_0010});
        vt.push_back('{4,  0, 0, 0, 8'b0100_0010});
        vt.push_back('{1,  0, 0, 0, 8'b0110_0011});
        vt.push_back('{1,  0, 0, 0, 8'b0100_0100});
        vt.push_back('{1,  0, 1, 0, 8'b0101_0101});
        vt.push_back('{3,  0, 0, 0, 8'b0101_0101});
        vt.push_back('{1,  1, 0, 0, 8'b1000_0000});
        // two timeouts -> fault, stray done ignored, restart clears fault
        vt.push_back('{12, 0, 0, 0, 8'b0110_0011});
        vt.push_back('{10, 0, 0, 0, 8'b0100_0100});
        vt.push_back('{1,  0, 0, 0, 8'b1000_0000});
        vt.push_back('{22, 0, 0, 0, 8'b0100_0100});
        vt.push_back('{1,  0, 0, 0, 8'b1000_1110});
        vt.push_back('{5,  0, 1, 0, 8'b1000_1110});
        vt.push_back('{1,  1, 0, 0, 8'b1000_0000});
        vt.push_back('{4,  0, 0, 0, 8'b0000_0001});
        vt.push_back('{3,  0, 0, 0, 8'b0100_0010});
        vt.push_back('{5,  0, 0, 0, 8'b0110_0011});
        // error on first attempt, success on second
        vt.push_back('{2,  0, 0, 1, 8'b1000_0000});
        vt.push_back('{13, 0, 0, 0, 8'b0100_0100});
        vt.push_back('{1,  0, 1, 0, 8'b0101_0101});
        // done+err together is an error; restart beats done and clears the retry count
        vt.push_back('{1,  1, 0, 0, 8'b1000_0000});
        vt.push_back('{14, 0, 1, 1, 8'b1000_0000});
        vt.push_back('{14, 1, 1, 0, 8'b1000_0000});
        vt.push_back('{14, 0, 0, 1, 8'b1000_0000});
        vt.push_back('{14, 0, 0, 1, 8'b1000_1110});
        vt.push_back('{1,  1, 0, 0, 8'b1000_0000});
    end

    initial begin
        #1;
        repeat (3) @(posedge dvp_clk);
        #1;
        check("reset_values", dut_vec, RESET_VEC);
        @(negedge dvp_clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < vt.size(); i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                if (k == vt[i].n - 1) step(vt[i].rs, vt[i].dn, vt[i].er);
                else step(1'b0, 1'b0, 1'b0);
            end
            check($sformatf("table[%0d]", i), dut_vec, vt[i].exp);
            check($sformatf("table_model[%0d]", i), dut_vec, model_out());
        end

        // stray cfg_done/cfg_err while booting, then async reset mid-boot
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("boot_stray_done", dut_vec, 8'b0100_0010);
        step(1'b0, 1'b0, 1'b1);
        check("boot_stray_err", dut_vec, 8'b0100_0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec, RESET_VEC);
        @(posedge dvp_clk);
        #1;
        check("reset_hold", dut_vec, RESET_VEC);
        @(negedge dvp_clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < T_CFG; k++) step(1'b0, 1'b0, 1'b0);
        check("post_reset_cfg_start", dut_vec, 8'b0110_0011);
        step(1'b0, 1'b0, 1'b0);
        check("post_reset_wait", dut_vec, 8'b0100_0100);

        // random traffic against the timeline model
        for (int c = 0; c < 3000; c++) begin
            bit rs, dn, er;
            rs = ($urandom_range(0, 149) == 0);
            dn = ($urandom_range(0, 7) == 0);
            er = ($urandom_range(0, 29) == 0);
            step(rs, dn, er);
            check("random", dut_vec, model_out());
            if (ready && fault) check("ready_fault_exclusive", {ready, fault}, 8'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dvp_sensor_seq
`default_nettype wire
